// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the IF/ID/EX/MEM pipe registers: load-use bubbles, EX redirects, memory waits.
// Define HAZARD_PERF_CNT_EN to add the stallCycles/flushCount/memWaitCycles performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W      = 3,
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] idSrcA,
  input  logic [REG_ADDR_W-1:0] idSrcB,
  input  logic                  idUsesA,
  input  logic                  idUsesB,
  input  logic [REG_ADDR_W-1:0] exDst,
  input  logic                  exRWrite,
  input  logic                  exRDataSel,
  input  logic                  exBr,
  input  logic                  exJmp,
  input  logic                  memReq,
  input  logic                  memRdy,
  output logic                  pcEn,
  output logic                  ifPipeEn,
  output logic                  ifPipeFlush,
  output logic                  idPipeEn,
  output logic                  idPipeFlush,
  output logic                  exPipeEn,
  output logic                  memPipeEn,
  output logic [1:0]            state,
  output logic                  memErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stallCycles,
  output logic [15:0]           flushCount,
  output logic [15:0]           memWaitCycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACT_FREEZE,
    ACT_REDIRECT,
    ACT_LOAD_USE,
    ACT_ADVANCE
  } act_e;

  typedef struct packed {
    logic pc_en;
    logic if_en;
    logic if_flush;
    logic id_en;
    logic id_flush;
    logic ex_en;
    logic mem_en;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE   = '{default: 1'b0};
  localparam ctrl_t CTRL_ADVANCE  = '{pc_en: 1'b1, if_en: 1'b1, if_flush: 1'b0, id_en: 1'b1,
                                      id_flush: 1'b0, ex_en: 1'b1, mem_en: 1'b1};
  localparam ctrl_t CTRL_REDIRECT = '{default: 1'b1};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_en: 1'b0, if_flush: 1'b0, id_en: 1'b1,
                                      id_flush: 1'b1, ex_en: 1'b1, mem_en: 1'b1};
  localparam ctrl_t CTRL_RESET    = '{pc_en: 1'b0, if_en: 1'b0, if_flush: 1'b1, id_en: 1'b0,
                                      id_flush: 1'b1, ex_en: 1'b0, mem_en: 1'b0};

  localparam logic [1:0] LU_LAST   = 2'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       mem_err_q, mem_err_d;
  ctrl_t      ctrl;

  logic load_use, redirect, mem_stall;
  act_e run_act;

  assign load_use  = exRWrite && exRDataSel && (exDst != '0) &&
                     ((idUsesA && (idSrcA == exDst)) || (idUsesB && (idSrcB == exDst)));
  assign redirect  = exBr || exJmp;
  assign mem_stall = memReq && !memRdy;

  // With memRdy high mem_stall is already 0, so MEM_WAIT completion reuses this RUN decision.
  always_comb begin
    if (mem_stall)     run_act = ACT_FREEZE;
    else if (redirect) run_act = ACT_REDIRECT;
    else if (load_use) run_act = ACT_LOAD_USE;
    else               run_act = ACT_ADVANCE;
  end

  function automatic ctrl_t act_ctrl(input act_e a);
    case (a)
      ACT_REDIRECT: return CTRL_REDIRECT;
      ACT_LOAD_USE: return CTRL_LOAD_USE;
      ACT_ADVANCE:  return CTRL_ADVANCE;
      default:      return CTRL_FREEZE;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      lu_cnt_q   <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lu_cnt_q   <= lu_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lu_cnt_d   = lu_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (run_act == ACT_FREEZE) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (run_act == ACT_LOAD_USE && LU_STALL_CYCLES > 1) begin
          state_d  = ST_LU_STALL;
          lu_cnt_d = 2'd1;
        end
      end
      ST_LU_STALL: begin
        if (!mem_stall) begin
          if (lu_cnt_q == LU_LAST) begin
            state_d  = ST_RUN;
            lu_cnt_d = '0;
          end else begin
            lu_cnt_d = lu_cnt_q + 2'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (memRdy) begin
          wait_cnt_d = '0;
          if (run_act == ACT_LOAD_USE && LU_STALL_CYCLES > 1) begin
            state_d  = ST_LU_STALL;
            lu_cnt_d = 2'd1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (Rst) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        ST_RUN:      ctrl = act_ctrl(run_act);
        ST_LU_STALL: ctrl = mem_stall ? CTRL_FREEZE : CTRL_LOAD_USE;
        ST_MEM_WAIT: ctrl = memRdy ? act_ctrl(run_act) : CTRL_FREEZE;
        default:     ctrl = CTRL_FREEZE;
      endcase
    end
  end

  assign pcEn        = ctrl.pc_en;
  assign ifPipeEn    = ctrl.if_en;
  assign ifPipeFlush = ctrl.if_flush;
  assign idPipeEn    = ctrl.id_en;
  assign idPipeFlush = ctrl.id_flush;
  assign exPipeEn    = ctrl.ex_en;
  assign memPipeEn   = ctrl.mem_en;
  assign state       = state_q;
  assign memErr      = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q, mwait_cnt_q;
  logic        live;

  assign live = (state_q != ST_HALT);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mwait_cnt_q <= '0;
    end else if (live) begin
      if (!ctrl.pc_en && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ctrl.if_flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
      if (state_q == ST_MEM_WAIT && !memRdy && mwait_cnt_q != 16'hFFFF)
        mwait_cnt_q <= mwait_cnt_q + 16'd1;
    end
  end

  assign stallCycles   = stall_cnt_q;
  assign flushCount    = flush_cnt_q;
  assign memWaitCycles = mwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (LU_STALL_CYCLES=2, MEM_TIMEOUT=4) against a
// cycle-level behavioural model of the stall/redirect rules, plus literal spot checks.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 3;
  localparam int LU = 2;
  localparam int TO = 4;

  // Control vector order: {pcEn, ifPipeEn, ifPipeFlush, idPipeEn, idPipeFlush, exPipeEn, memPipeEn}
  localparam logic [6:0] V_ADV = 7'b1101011;
  localparam logic [6:0] V_RED = 7'b1111111;
  localparam logic [6:0] V_LUS = 7'b0001111;
  localparam logic [6:0] V_FRZ = 7'b0000000;
  localparam logic [6:0] V_RST = 7'b0010100;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] idSrcA, idSrcB, exDst;
  logic          idUsesA, idUsesB, exRWrite, exRDataSel, exBr, exJmp, memReq, memRdy;
  logic          pcEn, ifPipeEn, ifPipeFlush, idPipeEn, idPipeFlush, exPipeEn, memPipeEn, memErr;
  logic [1:0]    state;
  logic [6:0]    ctrl_vec;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .LU_STALL_CYCLES(LU), .MEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .idSrcA(idSrcA), .idSrcB(idSrcB), .idUsesA(idUsesA), .idUsesB(idUsesB),
    .exDst(exDst), .exRWrite(exRWrite), .exRDataSel(exRDataSel),
    .exBr(exBr), .exJmp(exJmp), .memReq(memReq), .memRdy(memRdy),
    .pcEn(pcEn), .ifPipeEn(ifPipeEn), .ifPipeFlush(ifPipeFlush),
    .idPipeEn(idPipeEn), .idPipeFlush(idPipeFlush), .exPipeEn(exPipeEn),
    .memPipeEn(memPipeEn), .state(state), .memErr(memErr)
  );

  assign ctrl_vec = {pcEn, ifPipeEn, ifPipeFlush, idPipeEn, idPipeFlush, exPipeEn, memPipeEn};

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: bubbles still owed, memory-wait cycle number (0 = not waiting), halted, error flag.
  int m_lu_left = 0, m_wait = 0;
  bit m_halt = 0, m_err = 0;
  int n_lu_left = 0, n_wait = 0;
  bit n_halt = 0, n_err = 0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_lu_left = 0; m_wait = 0; m_halt = 0; m_err = 0;
    end else begin
      m_lu_left = n_lu_left; m_wait = n_wait; m_halt = n_halt; m_err = n_err;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      logic [6:0] ec;
      int  es;
      bit  ms, rd, lu, run;
      ms = memReq && !memRdy;
      rd = exBr || exJmp;
      lu = exRWrite && exRDataSel && exDst != 0 &&
           ((idUsesA && idSrcA == exDst) || (idUsesB && idSrcB == exDst));
      n_lu_left = m_lu_left; n_wait = m_wait; n_halt = m_halt; n_err = m_err;
      run = 1'b0;
      ec  = V_FRZ;
      es  = 0;
      if (Rst) begin
        ec = V_RST; es = 0;
        n_lu_left = 0; n_wait = 0; n_halt = 0; n_err = 0;
      end else if (m_halt) begin
        es = 3;
      end else if (m_wait > 0) begin
        es = 2;
        if (memRdy) begin
          n_wait = 0;
          run = 1'b1;
        end else if (m_wait == TO) begin
          n_halt = 1; n_err = 1;
        end else begin
          n_wait = m_wait + 1;
        end
      end else if (m_lu_left > 0) begin
        es = 1;
        if (!ms) begin
          ec = V_LUS;
          n_lu_left = m_lu_left - 1;
        end
      end else begin
        run = 1'b1;
      end
      if (run) begin
        if (ms) begin
          ec = V_FRZ; n_wait = 1;
        end else if (rd) begin
          ec = V_RED;
        end else if (lu) begin
          ec = V_LUS; n_lu_left = LU - 1;
        end else begin
          ec = V_ADV;
        end
      end
      check("ctrl", 32'(ctrl_vec), 32'(ec));
      check("state", 32'(state), 32'(es));
      check("memErr", 32'(memErr), (Rst ? 32'd0 : 32'(m_err)));
    end
  end

  task automatic drive(input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic ua,
                       input logic ub, input logic [AW-1:0] dst, input logic rw, input logic rds,
                       input logic br, input logic jmp, input logic mreq, input logic mrdy);
    idSrcA = sa; idSrcB = sb; idUsesA = ua; idUsesB = ub; exDst = dst;
    exRWrite = rw; exRDataSel = rds; exBr = br; exJmp = jmp; memReq = mreq; memRdy = mrdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [6:0] exp_c, input int exp_s);
    @(negedge Clk);
    check({name, "_ctrl"}, 32'(ctrl_vec), 32'(exp_c));
    check({name, "_state"}, 32'(state), 32'(exp_s));
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    cmp_en = 1'b1;
    tick();
    lit("reset", V_RST, 0); tick();
    Rst = 1'b0;

    idle(); lit("idle", V_ADV, 0); tick();

    // Load-use on reg 3 through source A: two bubbles, then advance
    drive(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0); lit("lu_c1", V_LUS, 0); tick();
    idle(); lit("lu_c2", V_LUS, 1); tick();
    idle(); lit("lu_done", V_ADV, 0); tick();

    // Register 0 and unused sources never hazard; non-load writer never hazards
    drive(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); lit("dst0", V_ADV, 0); tick();
    drive(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0); lit("unusedA", V_ADV, 0); tick();
    drive(4, 4, 1, 1, 4, 1, 0, 0, 0, 0, 0); tick();

    // Hazard through source B
    drive(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0); tick();
    idle(); tick();
    idle(); tick();

    // Redirect beats load-use
    drive(3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0); lit("br_lu", V_RED, 0); tick();
    idle(); lit("after_br", V_ADV, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();

    // Three frozen cycles, then completion with a jump
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); lit("mw_enter", V_FRZ, 0); tick();
    lit("mw1", V_FRZ, 2); tick();
    lit("mw2", V_FRZ, 2); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); lit("mw_done", V_RED, 2); tick();
    idle(); lit("mw_exit", V_ADV, 0); tick();

    // Completion carrying a load-use, then a memory stall while in LU_STALL
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1); lit("mw_lu", V_LUS, 2); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); lit("lu_frz", V_FRZ, 1); tick();
    idle(); lit("lu_resume", V_LUS, 1); tick();
    idle(); lit("lu_exit", V_ADV, 0); tick();

    // Ready in the same cycle: no stall
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); lit("mem_fast", V_ADV, 0); tick();

    // Reset asserted in the middle of MEM_WAIT
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    Rst = 1'b1;
    lit("rst_mid", V_RST, 0); tick();
    Rst = 1'b0;
    idle(); lit("post_rst", V_ADV, 0);
    check("post_rst_memErr", 32'(memErr), 32'd0);
    tick();

    // Timeout: RUN stall + MEM_WAIT cycles 1..4, then HALT
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) tick();
    lit("halt", V_FRZ, 3);
    check("halt_memErr", 32'(memErr), 32'd1);
    tick();
    drive(3, 0, 1, 0, 3, 1, 1, 0, 1, 1, 1); lit("halt_hold", V_FRZ, 3); tick();
    tick();
    Rst = 1'b1; tick();
    Rst = 1'b0;
    idle(); lit("final", V_ADV, 0);
    check("final_memErr", 32'(memErr), 32'd0);
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall controller for the 4-pipe-register processor (ifPipeReg, idPipeReg, exPipeReg, memPipeReg).
- Detects load-use hazards, taken branch/jump redirects resolved in EX, and multi-cycle memory waits.
- Drives per-stage enable/flush controls and the PC write enable.
- Small FSM plus counters sequence multi-cycle stalls and detect memory timeout.

Parameters:
REG_ADDR_W, 3, register-address width
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with MEM->EX forwarding, 2 without); legal 1..3
MEM_TIMEOUT, 64, MEM_WAIT cycles before memErr; legal 2..255

Ports:
Clk  in  1  processor clock, rising edge
Rst  in  1  asynchronous, active-high reset
idSrcA  in  REG_ADDR_W  source reg A of instruction in ID
idSrcB  in  REG_ADDR_W  source reg B of instruction in ID
idUsesA  in  1  ID instruction reads idSrcA
idUsesB  in  1  ID instruction reads idSrcB
exDst  in  REG_ADDR_W  destination reg of instruction in EX
exRWrite  in  1  EX instruction writes a register
exRDataSel  in  1  EX instruction's writeback data comes from memory (load)
exBr  in  1  taken branch resolved in EX
exJmp  in  1  jump in EX
memReq  in  1  MEM stage performing a load/store
memRdy  in  1  memory completes access this cycle
pcEn  out  1  PC update enable
ifPipeEn  out  1  ifPipeReg load enable
ifPipeFlush  out  1  ifPipeReg loads NOP
idPipeEn  out  1  idPipeReg load enable
idPipeFlush  out  1  idPipeReg loads bubble (all control fields 0)
exPipeEn  out  1  exPipeReg load enable
memPipeEn  out  1  memPipeReg load enable
state  out  2  FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2, HALT=3
memErr  out  1  sticky memory-timeout flag

Behaviour:
- Reset (Rst high, async): state=RUN, all counters 0, memErr=0. While Rst is high, force all *En=0, ifPipeFlush=1, idPipeFlush=1.
- Controls are combinational from state and inputs. State and counters are registered on the Clk rising edge.
- Terms:
  - loadUse = exRWrite & exRDataSel & exDst!=0 & ((idUsesA & idSrcA==exDst) | (idUsesB & idSrcB==exDst)). Register 0 never hazards.
  - redirect = exBr | exJmp.
  - memStall = memReq & ~memRdy.
- "Advance" means all *En=1 and both flushes 0.
- RUN, priority memStall > redirect > loadUse:
  - memStall: all *En=0, no flush. Next MEM_WAIT, waitCnt<=1.
  - redirect: all *En=1, ifPipeFlush=1, idPipeFlush=1. loadUse is ignored because the ID instruction is squashed. Stay RUN.
  - loadUse: pcEn=0, ifPipeEn=0, idPipeEn=1, idPipeFlush=1, exPipeEn=1, memPipeEn=1.
    - If LU_STALL_CYCLES=1: stay RUN.
    - Otherwise: next LU_STALL, luCnt<=1.
  - Otherwise: advance.
- LU_STALL:
  - Outputs are the same as the RUN loadUse case; luCnt increments.
  - When luCnt==LU_STALL_CYCLES-1 and the increment occurs: next RUN.
  - If memStall: freeze all (*En=0), luCnt holds, stay LU_STALL.
  - exBr/exJmp are ignored (EX holds a bubble).
- MEM_WAIT:
  - If memRdy: evaluate exactly as RUN with memStall=0 (the access completes this cycle). Next state follows RUN rules; waitCnt<=0.
  - Else: all *En=0; waitCnt increments.
  - If waitCnt==MEM_TIMEOUT and ~memRdy: memErr<=1, next HALT.
- HALT: all *En=0, flushes 0, memErr held at 1. Exit only via Rst.
- Counters (waitCnt 8-bit, luCnt 2-bit) never wrap within their legal parameter range.
- Rst asserted mid-stall: immediate return to reset values regardless of state.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs stallCycles[15:0] (cycles with pcEn=0 in RUN/LU_STALL/MEM_WAIT).
  - Adds flushCount[15:0] (cycles with redirect flush).
  - Adds memWaitCycles[15:0] (cycles in MEM_WAIT without memRdy).
  - All three saturate at 16'hFFFF and are cleared by Rst.
  - Not incremented in HALT.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Rst=1 mid-MEM_WAIT (waitCnt=5) -> same-cycle pcEn=0, ifPipeFlush=1, idPipeFlush=1; after release: state=0, memErr=0.
- exRWrite=1, exRDataSel=1, exDst=3, idUsesA=1, idSrcA=3, LU_STALL_CYCLES=2 -> two consecutive cycles of pcEn=0/ifPipeEn=0/idPipeFlush=1 (state 0 then 1), then advance with state=0.
- Same hazard but exDst=0 or idUsesA=0 -> no stall, all *En=1.
- exBr=1 together with a loadUse match -> ifPipeFlush=1, idPipeFlush=1, pcEn=1, state stays 0 (redirect wins).
- memReq=1, memRdy=0 for 3 cycles, then memRdy=1 with exJmp=1 -> 3 frozen cycles (state=2), then flush cycle with all *En=1, state=0.
- MEM_TIMEOUT=4, memReq=1, memRdy=0 held -> memErr=1 and state=3 after the 4th MEM_WAIT cycle; remains until Rst even if memRdy later rises.
